// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_BYTE  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_BYTE  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } i2c_tgt_state_t;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter for one I2C line.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Idle I2C lines are pulled high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        rise  <= sync[1];
        fall  <= ~sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing an 8-bit-addressed register space with an auto-incrementing pointer.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h42,
  parameter int         FILTER_LEN = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           scl_in,
  input  logic           sda_in,
  output logic           sda_oe,
  output logic [7:0]     reg_addr,
  input  logic [7:0]     reg_rdata,
  output logic [7:0]     reg_wdata,
  output logic           reg_we,
  output logic           reg_rd,
  output logic           busy,
  output i2c_tgt_state_t fsm_state
);

  // Register-side strobes: reg_we is a single-clk write of reg_wdata to reg_addr;
  // reg_rd is a single-clk mark that reg_rdata was captured. Neither waits for a ready.

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (scl_in),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (sda_in),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  i2c_tgt_state_t state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           rw;
  logic           first_byte;
  logic           rd_acked;
  logic           incr_pending;
  logic           start_det;
  logic           stop_det;
  logic [7:0]     rx_byte;
  logic           addr_match;
  logic           load_tx;

  assign start_det  = sda_fall & scl_lvl;
  assign stop_det   = sda_rise & scl_lvl;
  assign rx_byte    = {shreg[6:0], sda_lvl};
  assign addr_match = (rx_byte[7:1] == DEV_ADDR);
  assign fsm_state  = state;

  // Loading a transmit byte happens at the SCL fall that ends either the
  // address ACK of a read or an ACKed read byte.
  always_comb begin
    load_tx = 1'b0;
    if (!start_det && !stop_det && scl_fall) begin
      if (state == ST_ADDR_ACK && sda_oe && rw == I2C_RW_READ)
        load_tx = 1'b1;
      if (state == ST_RD_ACK && rd_acked)
        load_tx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      rw           <= 1'b0;
      first_byte   <= 1'b0;
      rd_acked     <= 1'b0;
      incr_pending <= 1'b0;
      sda_oe       <= 1'b0;
      busy         <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      reg_we       <= 1'b0;
      reg_rd       <= 1'b0;
    end else begin
      reg_we       <= 1'b0;
      reg_rd       <= 1'b0;
      incr_pending <= 1'b0;
      if (incr_pending)
        reg_addr <= reg_addr + 8'd1;

      if (start_det) begin
        state      <= ST_ADDR;
        bit_cnt    <= '0;
        sda_oe     <= 1'b0;
        first_byte <= 1'b1;
        rd_acked   <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (addr_match) begin
                  state <= ST_ADDR_ACK;
                  busy  <= 1'b1;
                  rw    <= sda_lvl;
                end else begin
                  state <= ST_IGNORE;
                  busy  <= 1'b0;
                end
              end
            end
          end

          // sda_oe doubles as the ACK phase marker: low until the fall
          // ending bit 8, high for the ACK bit itself.
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (rw != I2C_RW_READ) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= ST_WR_BYTE;
              end
            end
          end

          ST_WR_BYTE: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= ST_WR_ACK;
                if (first_byte) begin
                  reg_addr   <= rx_byte;
                  first_byte <= 1'b0;
                end else begin
                  reg_wdata    <= rx_byte;
                  reg_we       <= 1'b1;
                  incr_pending <= 1'b1;
                end
              end
            end
          end

          ST_WR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= ST_WR_BYTE;
              end
            end
          end

          // bit_cnt wraps to 0 after the eighth rise, which marks the byte end.
          ST_RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe   <= 1'b0;
                rd_acked <= 1'b0;
                state    <= ST_RD_ACK;
              end else begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
              end
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_lvl == I2C_NACK)
                state <= ST_IGNORE;
              else
                rd_acked <= 1'b1;
            end
          end

          default: begin
          end
        endcase

        if (load_tx) begin
          shreg        <= reg_rdata;
          reg_rd       <= 1'b1;
          incr_pending <= 1'b1;
          sda_oe       <= ~reg_rdata[7];
          bit_cnt      <= '0;
          rd_acked     <= 1'b0;
          state        <= ST_RD_BYTE;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C controller, pointer/data reference model and strobe scoreboard.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam logic [6:0] DEV = 7'h42;
  localparam int         Q   = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic           scl_in = 1'b1;
  logic           sda_ctrl = 1'b1;
  logic           sda_bus;
  logic           sda_oe;
  logic [7:0]     reg_addr;
  logic [7:0]     reg_rdata;
  logic [7:0]     reg_wdata;
  logic           reg_we;
  logic           reg_rd;
  logic           busy;
  i2c_tgt_state_t fsm_state;

  assign sda_bus   = sda_ctrl & ~sda_oe;
  assign reg_rdata = reg_addr ^ 8'hFF;

  i2c_target_regs #(.DEV_ADDR(DEV), .FILTER_LEN(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_rdata (reg_rdata),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rd    (reg_rd),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // scoreboard
  logic [15:0] exp_q[$];
  logic [7:0]  rd_exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int oe_cnt   = 0;
  int busy_cnt = 0;
  int we_cnt   = 0;
  int rd_cnt   = 0;
  logic [7:0] model_ptr = 8'h00;
  logic [7:0] wbuf[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
      if (reg_we) begin
        we_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_we: got %h:%h, expected no write", reg_addr, reg_wdata);
        end else begin
          chk("write_strobe", {reg_addr, reg_wdata}, exp_q.pop_front());
        end
      end
      if (reg_rd) begin
        rd_cnt++;
        if (rd_exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rd: got addr %h, expected no read", reg_addr);
        end else begin
          chk("read_strobe_addr", {8'h00, reg_addr}, {8'h00, rd_exp_q.pop_front()});
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_bit(input logic b, output logic s);
    tick(Q); sda_ctrl = b;
    tick(Q); scl_in = 1'b1;
    tick(Q); s = sda_bus;
    tick(Q); scl_in = 1'b0;
  endtask

  task automatic bus_start();
    tick(Q); sda_ctrl = 1'b1;
    tick(Q); scl_in = 1'b1;
    tick(Q); sda_ctrl = 1'b0;
    tick(Q); scl_in = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); sda_ctrl = 1'b0;
    tick(Q); scl_in = 1'b1;
    tick(Q); sda_ctrl = 1'b1;
    tick(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ackv, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(ackv, s);
  endtask

  task automatic wr_txn(input logic [6:0] dev, input logic [7:0] ptr, input int n);
    logic a;
    logic m;
    logic want_ack;
    m = (dev == DEV);
    want_ack = m ? I2C_ACK : I2C_NACK;
    bus_start();
    write_byte({dev, 1'b0}, a);
    chk("wr_addr_ack", 16'(a), 16'(want_ack));
    chk("wr_busy", 16'(busy), 16'(m));
    write_byte(ptr, a);
    chk("wr_ptr_ack", 16'(a), 16'(want_ack));
    if (m) model_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      if (m) begin
        exp_q.push_back({model_ptr, wbuf[i]});
        model_ptr = model_ptr + 8'd1;
      end
      write_byte(wbuf[i], a);
      chk("wr_data_ack", 16'(a), 16'(want_ack));
    end
    bus_stop();
    chk("wr_busy_after_stop", 16'(busy), 16'h0);
  endtask

  task automatic rd_txn(input logic [6:0] dev, input logic set_ptr, input logic [7:0] ptr, input int n);
    logic a;
    logic m;
    logic want_ack;
    logic [7:0] d;
    m = (dev == DEV);
    want_ack = m ? I2C_ACK : I2C_NACK;
    bus_start();
    if (set_ptr) begin
      write_byte({dev, 1'b0}, a);
      chk("rd_waddr_ack", 16'(a), 16'(want_ack));
      write_byte(ptr, a);
      chk("rd_ptr_ack", 16'(a), 16'(want_ack));
      if (m) model_ptr = ptr;
      bus_start();
    end
    write_byte({dev, 1'b1}, a);
    chk("rd_addr_ack", 16'(a), 16'(want_ack));
    chk("rd_busy", 16'(busy), 16'(m));
    if (m) begin
      for (int i = 0; i < n; i++) begin
        rd_exp_q.push_back(model_ptr);
        read_byte((i == n - 1) ? I2C_NACK : I2C_ACK, d);
        chk("rd_data", {8'h00, d}, {8'h00, model_ptr ^ 8'hFF});
        model_ptr = model_ptr + 8'd1;
      end
      tick(Q);
      chk("rd_sda_released", 16'(sda_oe), 16'h0);
    end
    bus_stop();
    chk("rd_busy_after_stop", 16'(busy), 16'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int oe0, b0, w0, r0;
    logic s;
    logic [7:0] b;
    logic a;

    tick(5);
    chk("reset_sda_oe", 16'(sda_oe), 16'h0);
    chk("reset_reg_addr", {8'h00, reg_addr}, 16'h0);
    chk("reset_reg_wdata", {8'h00, reg_wdata}, 16'h0);
    chk("reset_reg_we", 16'(reg_we), 16'h0);
    chk("reset_reg_rd", 16'(reg_rd), 16'h0);
    chk("reset_busy", 16'(busy), 16'h0);
    chk("reset_state", 16'(fsm_state), 16'(ST_IDLE));
    rst_n = 1'b1;
    tick(10);

    // directed write
    w0 = we_cnt;
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    wr_txn(DEV, 8'h10, 2);
    tick(4);
    chk("write_final_ptr", {8'h00, reg_addr}, 16'h0012);
    chk("write_we_count", 16'(we_cnt - w0), 16'd2);

    // read with repeated START
    r0 = rd_cnt;
    rd_txn(DEV, 1'b1, 8'h20, 3);
    chk("read_rd_count", 16'(rd_cnt - r0), 16'd3);

    // wrong address
    oe0 = oe_cnt; b0 = busy_cnt; w0 = we_cnt;
    wr_txn(7'h48, 8'h00, 0);
    chk("wrong_addr_oe", 16'(oe_cnt - oe0), 16'h0);
    chk("wrong_addr_busy", 16'(busy_cnt - b0), 16'h0);
    chk("wrong_addr_we", 16'(we_cnt - w0), 16'h0);
    chk("wrong_addr_ptr", {8'h00, reg_addr}, {8'h00, model_ptr});

    // pointer wrap, then a read that reuses the persisted pointer
    rd_txn(DEV, 1'b1, 8'hFF, 2);
    rd_txn(DEV, 1'b0, 8'h00, 2);

    // 1-clk SCL glitch inside the address byte
    b = {DEV, 1'b0};
    bus_start();
    bus_bit(b[7], s);
    tick(2); scl_in = 1'b1; tick(1); scl_in = 1'b0;
    for (int i = 6; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, a);
    chk("glitch_addr_ack", 16'(a), 16'(I2C_ACK));
    write_byte(8'h40, a);
    model_ptr = 8'h40;
    exp_q.push_back({model_ptr, 8'h77});
    model_ptr = model_ptr + 8'd1;
    write_byte(8'h77, a);
    chk("glitch_data_ack", 16'(a), 16'(I2C_ACK));
    bus_stop();

    // START after 4 address bits
    bus_start();
    for (int i = 7; i >= 4; i--) bus_bit(b[i], s);
    bus_start();
    write_byte(b, a);
    chk("midbyte_restart_ack", 16'(a), 16'(I2C_ACK));
    write_byte(8'h50, a);
    model_ptr = 8'h50;
    chk("midbyte_ptr_ack", 16'(a), 16'(I2C_ACK));
    bus_stop();
    chk("midbyte_ptr", {8'h00, reg_addr}, 16'h0050);

    // reset while the target is ACKing
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    for (int k = 0; k < 40 && !sda_oe; k++) tick(1);
    chk("ack_before_reset", 16'(sda_oe), 16'h1);
    #3 rst_n = 1'b0;
    #1 chk("reset_async_release", 16'(sda_oe), 16'h0);
    tick(3);
    rst_n = 1'b1;
    model_ptr = 8'h00;
    tick(10);
    chk("post_reset_state", 16'(fsm_state), 16'(ST_IDLE));
    chk("post_reset_ptr", {8'h00, reg_addr}, 16'h0);
    bus_stop();
    wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
    wr_txn(DEV, 8'h30, 2);

    // randomized transactions
    for (int t = 0; t < 10; t++) begin
      logic [6:0] dev;
      int n;
      int kind;
      if ($urandom_range(0, 3) == 0) begin
        dev = 7'($urandom_range(0, 127));
        if (dev == DEV) dev = dev ^ 7'h01;
      end else begin
        dev = DEV;
      end
      n = int'($urandom_range(1, 4));
      kind = int'($urandom_range(0, 2));
      for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom_range(0, 255));
      case (kind)
        0: wr_txn(dev, 8'($urandom_range(0, 255)), n);
        1: rd_txn(dev, 1'b1, 8'($urandom_range(0, 255)), n);
        default: rd_txn(dev, 1'b0, 8'h00, n);
      endcase
    end

    tick(20);
    chk("write_queue_drained", 16'(exp_q.size()), 16'h0);
    chk("read_queue_drained", 16'(rd_exp_q.size()), 16'h0);
    chk("final_ptr", {8'h00, reg_addr}, {8'h00, model_ptr});
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (responder) that makes an 8-bit-addressed register space readable and writable by an external I2C controller. It is the counterpart of the I2C_Driver initiator used for the altimeter, IMU and camera buses, so a ground-test rig or a second Mojo board can read the Sensor_Reg image over I2C. It samples SCL/SDA with the system clock and drives SDA open-drain. It never drives or stretches SCL.

## Interface
- `DEV_ADDR`, default 7'h42: 7-bit target address the block acknowledges.
- `FILTER_LEN`, default 3: number of consecutive equal synchronized samples required before a line change is accepted.
- `clk` in, 1: system clock, 50 MHz. Must be at least 20× SCL frequency.
- `rst_n` in, 1: asynchronous, active-low reset.
- `scl_in` in, 1: raw SCL pin value.
- `sda_in` in, 1: raw SDA pin value.
- `sda_oe` out, 1: 1 = pull SDA low; 0 = release. The top level builds `inout` as `sda_oe ? 1'b0 : 1'bz`.
- `reg_addr` out, 8: register pointer.
- `reg_rdata` in, 8: data at `reg_addr`. Must be valid 1 clk after `reg_addr` changes.
- `reg_wdata` out, 8: write data; valid while `reg_we` = 1.
- `reg_we` out, 1: one-clk write strobe.
- `reg_rd` out, 1: one-clk pulse when `reg_rdata` is captured for transmit.
- `busy` out, 1: 1 from an address match until STOP, or until a START that addresses another target.

## Operation
- **Line conditioning.** Each line passes through a 2-flop synchronizer, then the glitch filter. Detected events on the filtered lines:
  - `scl_rise`, `scl_fall`.
  - START: SDA falls while SCL = 1.
  - STOP: SDA rises while SCL = 1.
- **Data sampling.** Data bits are sampled on `scl_rise`, MSB first. SDA is changed only on `scl_fall`.
- **State machine.** States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
  - Any state + START → ADDR, with bit counter = 0. This covers repeated START and START mid-byte.
  - Any state + STOP → IDLE; `sda_oe` = 0, `busy` = 0.
  - ADDR: after 8 bits, if addr[7:1] == `DEV_ADDR` → ADDR_ACK, `busy` = 1. Otherwise → IGNORE, which waits for START or STOP.
  - ADDR_ACK: on the `scl_fall` that ends bit 8, assert `sda_oe`. On the next `scl_fall`, release it. Then go to WR_BYTE if R/W = 0, or to RD_BYTE if R/W = 1.
  - On entry to RD_BYTE (at that `scl_fall`): load the shift register from `reg_rdata`, pulse `reg_rd`, then `reg_addr` ← `reg_addr` + 1. Drive bit 7 immediately: `sda_oe` = ~bit.
  - WR_BYTE: after 8 bits → WR_ACK.
    - First byte after the address is the pointer: `reg_addr` ← byte.
    - Later bytes: `reg_wdata` ← byte and `reg_we` pulses for 1 clk, coincident with the `scl_rise` of bit 0. `reg_addr` increments on the following clk.
    - Every written byte is ACKed.
  - RD_BYTE: after 8 bits, release SDA → RD_ACK. Sample the controller's ACK on `scl_rise`.
    - ACK (0) → reload from `reg_rdata` as above and go to RD_BYTE.
    - NACK (1) → IGNORE.
- **Pointer.** `reg_addr` wraps 8'hFF → 8'h00. The pointer persists across transactions, so a read with no write selects the last pointer.
- **Simultaneous events.** START/STOP take priority over bit events in the same clk.
- **Reset values.** `sda_oe` = 0, `reg_addr` = 0, `reg_wdata` = 0, `reg_we` = 0, `reg_rd` = 0, `busy` = 0. State = IDLE.
- **Reset mid-transfer.** SDA is released asynchronously; the block resumes in IDLE.

## Timing
- Event latency: pin change → detected event = 2 + `FILTER_LEN` clks.
- `sda_oe` changes 1 clk after the detected `scl_fall`. Data-out hold after the SCL edge is at least (3 + `FILTER_LEN`) × 20 ns = 120 ns.
- `reg_rd` and the shift-register load occur in the same clk. The pointer increments in the next clk.
- SDA is not driven low during the ACK bit on a non-matching address, nor after a controller NACK.

## Structure
- Shared package `i2c_pkg`:
  - state enum `i2c_tgt_state_t`.
  - constants `I2C_ACK` = 1'b0, `I2C_NACK` = 1'b1, `I2C_RW_READ` = 1'b1.
- Sub-module `i2c_line_filter`: synchronizer plus `FILTER_LEN` filter, with `rise`/`fall` outputs. Instantiated once per line.
- The top module holds the FSM, the bit counter (3 bits), the shift register, the pointer and the first-byte flag.

## Test plan
- **Write.** START, 0x84, 0x10, 0xA5, 0x5A, STOP → ACK on every byte. `reg_we` pulses twice: (0x10, 0xA5) then (0x11, 0x5A). Final `reg_addr` = 0x12.
- **Read with repeated START.** START, 0x84, 0x20, rSTART, 0x85, read 3 bytes (ACK, ACK, NACK), STOP; `reg_rdata` model = addr ^ 8'hFF → bytes 0xDF, 0xDE, 0xDD. `reg_rd` pulses 3×. SDA released after the NACK.
- **Wrong address.** START, 0x90, 0x00, STOP → SDA never driven; `busy` stays 0; no `reg_we`.
- **Pointer wrap.** Pointer 0xFF, read 2 bytes → data from 0xFF then 0x00.
- **Glitch and mid-byte events.**
  - 1-clk SCL glitch → no bit counted.
  - START after 4 address bits → address restarts and the next full byte is ACKed.
- **Reset mid-transfer.** Assert `rst_n` = 0 while the block is ACKing → `sda_oe` = 0 within the same clk; after release, IDLE. A STOP then a new transaction succeeds.
